bchecc_fix: RTL

//  Correction write-back stage directly downstream of the BCH decoder. Queues
//  (byte address, bit-flip mask) pairs reported by the Chien search and applies

---
 rtl/bchecc_fix.sv | 116 +++++++++++
 1 files changed

// File: rtl/bchecc_fix.sv
// BCH correction write-back: queues (address, flip-mask) reports and applies each
// as a read-modify-write on the byte-wide page buffer, then signals page completion.
module bchecc_fix #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              err_vld_i,
    input  logic [ADDR_W-1:0] err_addr_i,
    input  logic [7:0]        err_mask_i,
    input  logic              dec_done_i,
    output logic              err_rdy_o,
    output logic              buf_req_o,
    input  logic              buf_gnt_i,
    output logic              buf_we_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    output logic [7:0]        buf_wdata_o,
    input  logic [7:0]        buf_rdata_i,
    output logic              fix_busy_o,
    output logic              fix_done_o,
    output logic [CNT_W-1:0]  fix_cnt_o,
    output logic              ovf_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW    = PTR_W + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [1:0] {StIdle, StRd, StRdw, StWr} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr_mem [DEPTH];
    logic [7:0]        r_mask_mem [DEPTH];
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [CW-1:0]     r_count;
    logic [7:0]        r_wdata;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ovf;
    logic              r_done;

    logic              w_clear;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_head_addr;
    logic [7:0]        w_head_mask;

    assign w_clear     = !rst_n || clr_i;
    assign err_rdy_o   = (r_count != FULL_CNT);
    // Zero-mask reports carry no correction and are silently discarded.
    assign w_push      = err_vld_i && err_rdy_o && (err_mask_i != 8'h00);
    assign w_pop       = (r_state == StWr) && buf_gnt_i;
    assign w_head_addr = r_addr_mem[r_rp];
    assign w_head_mask = r_mask_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push && !w_clear) begin
            r_addr_mem[r_wp] <= err_addr_i;
            r_mask_mem[r_wp] <= err_mask_i;
        end
    end

    // A report pushed while idle starts its read on the very next cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: if ((r_count != '0) || w_push) w_state_nxt = StRd;
            StRd:   if (buf_gnt_i) w_state_nxt = StRdw;
            StRdw:  w_state_nxt = StWr;
            StWr:   if (buf_gnt_i) w_state_nxt = (r_count > ONE_CNT) ? StRd : StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= StIdle;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
            if (r_state == StRdw) r_wdata <= buf_rdata_i ^ w_head_mask;
            if (w_pop && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
            if (err_vld_i && !err_rdy_o) r_ovf <= 1'b1;
            r_done <= dec_done_i || (r_done && !fix_done_o);
        end
    end

    // Address and data are forced to zero whenever no access is requested.
    assign buf_req_o   = (r_state == StRd) || (r_state == StWr);
    assign buf_we_o    = (r_state == StWr);
    assign buf_addr_o  = buf_req_o ? w_head_addr : '0;
    assign buf_wdata_o = buf_we_o ? r_wdata : 8'h00;
    assign fix_busy_o  = (r_count != '0) || (r_state != StIdle);
    assign fix_done_o  = r_done && (r_count == '0) && (r_state == StIdle);
    assign fix_cnt_o   = r_cnt;
    assign ovf_o       = r_ovf;

endmodule
